// File: rtl/r2sdf_bfly_stage.sv
// One radix-2 single-path delay-feedback butterfly stage.
// Emits sums immediately and differences one half-block later, with the twiddle index for each.
module r2sdf_bfly_stage #(
  parameter int DATA_WIDTH = 20,
  parameter int DELAY      = 4,
  parameter int TW_STRIDE  = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         flush,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic        [ADDR_WIDTH-1:0] tw_addr,
  output logic                         out_is_diff
);

  localparam int BLOCK = 2 * DELAY;
  localparam int CW    = $clog2(BLOCK);

  logic [CW-1:0] cnt;
  logic          primed;

  logic signed [DATA_WIDTH-1:0] dl_re [DELAY];
  logic signed [DATA_WIDTH-1:0] dl_im [DELAY];

  logic                         phase_b;
  logic [CW-1:0]                k;
  logic                         flush_adv;
  logic                         adv;
  logic                         last_k;
  logic                         cnt_wrap;
  logic signed [DATA_WIDTH-1:0] src_re, src_im;
  logic signed [DATA_WIDTH-1:0] head_re, head_im;
  logic signed [DATA_WIDTH-1:0] sum_re, sum_im;
  logic signed [DATA_WIDTH-1:0] dif_re, dif_im;
  logic signed [DATA_WIDTH-1:0] push_re, push_im;
  logic        [ADDR_WIDTH-1:0] tw_next;

  assign phase_b   = (cnt >= CW'(DELAY));
  assign k         = phase_b ? (cnt - CW'(DELAY)) : cnt;
  assign last_k    = (k == CW'(DELAY - 1));
  assign cnt_wrap  = (cnt == CW'(BLOCK - 1));
  assign flush_adv = flush & ~valid_in & ~phase_b & primed;
  assign adv       = valid_in | flush_adv;

  // A flush advance behaves exactly like an input of 0+0j.
  assign src_re  = valid_in ? in_real : '0;
  assign src_im  = valid_in ? in_imag : '0;
  assign head_re = dl_re[DELAY-1];
  assign head_im = dl_im[DELAY-1];

  // Evaluating at DATA_WIDTH bits gives the same two's-complement wrap as full precision then truncate.
  assign sum_re  = head_re + src_re;
  assign sum_im  = head_im + src_im;
  assign dif_re  = head_re - src_re;
  assign dif_im  = head_im - src_im;
  assign push_re = phase_b ? dif_re : src_re;
  assign push_im = phase_b ? dif_im : src_im;
  assign tw_next = ADDR_WIDTH'(k) * ADDR_WIDTH'(TW_STRIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (adv) begin
      dl_re[0] <= push_re;
      dl_im[0] <= push_im;
      for (int i = 1; i < DELAY; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  // The last flushed difference closes the block so the next real sample starts a fresh one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (flush_adv) begin
      if (last_k) begin
        cnt    <= '0;
        primed <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (valid_in) begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) begin
        primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      tw_addr     <= '0;
      out_is_diff <= 1'b0;
    end else if (adv && phase_b) begin
      valid_out   <= 1'b1;
      out_real    <= sum_re;
      out_imag    <= sum_im;
      tw_addr     <= '0;
      out_is_diff <= 1'b0;
    end else if (adv && primed) begin
      valid_out   <= 1'b1;
      out_real    <= head_re;
      out_imag    <= head_im;
      tw_addr     <= tw_next;
      out_is_diff <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2sdf_bfly_stage.sv
// Directed and randomized bench for r2sdf_bfly_stage (D=4, stride 2) against a block-level model.
module tb_r2sdf_bfly_stage;

  localparam int DW = 20;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_imag = '0;
  logic                 flush = 1'b0;
  logic                 valid_out;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic        [AW-1:0] tw_addr;
  logic                 out_is_diff;

  int errors = 0;
  int checks = 0;

  // Model: current block position, first-half samples, pending differences, expected outputs
  int                   m_pos = 0;
  bit                   m_primed = 1'b0;
  logic signed [DW-1:0] m_br [D];
  logic signed [DW-1:0] m_bi [D];
  logic signed [DW-1:0] m_dr [D];
  logic signed [DW-1:0] m_di [D];
  logic                 e_valid = 1'b0;
  logic signed [DW-1:0] e_re = '0;
  logic signed [DW-1:0] e_im = '0;
  logic        [AW-1:0] e_tw = '0;
  logic                 e_diff = 1'b0;

  r2sdf_bfly_stage #(
    .DATA_WIDTH(DW),
    .DELAY     (D),
    .TW_STRIDE (S),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .flush      (flush),
    .valid_out  (valid_out),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .tw_addr    (tw_addr),
    .out_is_diff(out_is_diff)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_pos    = 0;
    m_primed = 1'b0;
    e_valid  = 1'b0;
    e_re     = '0;
    e_im     = '0;
    e_tw     = '0;
    e_diff   = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (valid_out === e_valid) else begin
      errors++;
      $error("[TB] FAIL %s valid_out: got %0d expected %0d", tag, valid_out, e_valid);
    end
    checks++;
    assert (out_real === e_re) else begin
      errors++;
      $error("[TB] FAIL %s out_real: got %0d expected %0d", tag, out_real, e_re);
    end
    checks++;
    assert (out_imag === e_im) else begin
      errors++;
      $error("[TB] FAIL %s out_imag: got %0d expected %0d", tag, out_imag, e_im);
    end
    checks++;
    assert (tw_addr === e_tw) else begin
      errors++;
      $error("[TB] FAIL %s tw_addr: got %0d expected %0d", tag, tw_addr, e_tw);
    end
    checks++;
    assert (out_is_diff === e_diff) else begin
      errors++;
      $error("[TB] FAIL %s out_is_diff: got %0d expected %0d", tag, out_is_diff, e_diff);
    end
  endtask

  // One clock: drive on the falling edge, update the model, check 1 time unit after the rising edge.
  task automatic applyStimulus(input string tag, input logic v, input logic fl,
                               input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    @(negedge clk);
    valid_in = v;
    flush    = fl;
    in_real  = re;
    in_imag  = im;
    e_valid  = 1'b0;
    if (v) begin
      if (m_pos < D) begin
        if (m_primed) begin
          e_valid = 1'b1;
          e_re    = m_dr[m_pos];
          e_im    = m_di[m_pos];
          e_tw    = AW'(m_pos * S);
          e_diff  = 1'b1;
        end
        m_br[m_pos] = re;
        m_bi[m_pos] = im;
      end else begin
        e_valid = 1'b1;
        e_re    = m_br[m_pos-D] + re;
        e_im    = m_bi[m_pos-D] + im;
        e_tw    = '0;
        e_diff  = 1'b0;
        m_dr[m_pos-D] = m_br[m_pos-D] - re;
        m_di[m_pos-D] = m_bi[m_pos-D] - im;
        if (m_pos == 2*D-1) m_primed = 1'b1;
      end
      m_pos = (m_pos + 1) % (2*D);
    end else if (fl && m_pos < D && m_primed) begin
      e_valid = 1'b1;
      e_re    = m_dr[m_pos];
      e_im    = m_di[m_pos];
      e_tw    = AW'(m_pos * S);
      e_diff  = 1'b1;
      m_br[m_pos] = '0;
      m_bi[m_pos] = '0;
      if (m_pos == D-1) begin
        m_pos    = 0;
        m_primed = 1'b0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic resetMid(input string tag);
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    #1 checkOutput("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) applyStimulus("blk1", 1'b1, 1'b0, DW'(i), '0);
    for (int i = 0; i < 4; i++)  applyStimulus("flush1", 1'b0, 1'b1, '0, '0);
    applyStimulus("flush_unprimed", 1'b0, 1'b1, '0, '0);
    applyStimulus("idle", 1'b0, 1'b0, '0, '0);

    for (int i = 1; i <= 8; i++)   applyStimulus("stream_b1", 1'b1, 1'b0, DW'(i), DW'(-i));
    for (int i = 10; i <= 17; i++) applyStimulus("stream_b2", 1'b1, 1'b0, DW'(i), DW'(3*i));
    applyStimulus("flush_phaseA_partial", 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++)    applyStimulus("flush2", 1'b0, 1'b1, '0, '0);

    applyStimulus("ovf_sum_x0", 1'b1, 1'b0, 20'sd524287, -20'sd524288);
    for (int i = 1; i < 4; i++) applyStimulus("ovf_sum_pad", 1'b1, 1'b0, '0, '0);
    applyStimulus("ovf_sum_x4", 1'b1, 1'b0, 20'sd1, 20'sd1);
    for (int i = 5; i < 8; i++) applyStimulus("ovf_sum_pad", 1'b1, 1'b0, '0, '0);
    applyStimulus("ovf_dif_x0", 1'b1, 1'b0, -20'sd524288, 20'sd524287);
    for (int i = 1; i < 4; i++) applyStimulus("ovf_dif_pad", 1'b1, 1'b0, '0, '0);
    applyStimulus("ovf_dif_x4", 1'b1, 1'b0, 20'sd1, -20'sd1);
    for (int i = 5; i < 8; i++) applyStimulus("ovf_dif_pad", 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus("ovf_flush", 1'b0, 1'b1, '0, '0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus("gap_in", 1'b1, (i == 3), DW'(i), '0);
      applyStimulus("gap_idle", 1'b0, (i > 4), '0, '0);
    end
    for (int i = 0; i < 4; i++) applyStimulus("gap_flush", 1'b0, 1'b1, '0, '0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                    DW'($urandom), DW'($urandom));
    end

    for (int i = 0; i < 8; i++) applyStimulus("pre_reset", 1'b1, 1'b0, DW'(i + 100), DW'(i));
    for (int i = 0; i < 3; i++) applyStimulus("pre_reset", 1'b1, 1'b0, DW'(i + 50), '0);
    resetMid("async_reset");
    for (int i = 0; i < 8; i++) applyStimulus("post_reset", 1'b1, 1'b0, DW'(2*i + 7), DW'(-i));
    for (int i = 0; i < 4; i++) applyStimulus("post_reset_flush", 1'b0, 1'b1, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
